// File: rtl/sci_pkg.sv
// Shared SCI definitions: frame state encoding, WNR polarity and frame length.
package sci_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_WACK  = 3'd4,
    S_RWAIT = 3'd5,
    S_RDATA = 3'd6,
    S_GAP   = 3'd7
  } sci_state_e;

  // WNR bit value meaning "write"; the slave decodes the same polarity.
  localparam logic SCI_WNR_WRITE = 1'b1;

  function automatic int unsigned sci_frame_len(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/sci_master_if.sv
// Command/response handshake plus SCI serial lines between controller, master and slave.
interface sci_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WNR;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  SCI_CSN;
  logic                  SCI_REQ;
  logic                  SCI_RESP;
  logic                  SCI_ACK;

  modport master (
    input  CMD_VALID, CMD_WNR, CMD_ADDR, CMD_WDATA, SCI_RESP, SCI_ACK,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, SCI_CSN, SCI_REQ
  );

  modport slave (
    output CMD_VALID, CMD_WNR, CMD_ADDR, CMD_WDATA, SCI_RESP, SCI_ACK,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, SCI_CSN, SCI_REQ
  );
endinterface

// File: rtl/sci_frame_shifter.sv
// PISO for the outgoing wnr/addr/wdata frame and SIPO for incoming read data.
module sci_frame_shifter
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  capture,
  input  logic                  wnr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  resp,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] rd_next
);
  localparam int FL = sci_frame_len(ADDR_WIDTH, DATA_WIDTH);

  logic [FL-1:0]         piso;
  logic [DATA_WIDTH-1:0] sipo;

  // Reads load zeros in the data slot so REQ idles low once the address is out.
  assign req     = piso[FL-1];
  assign rd_next = DATA_WIDTH'({sipo, resp});

  always_ff @(posedge CLK) begin
    if (RST) begin
      piso <= '0;
      sipo <= '0;
    end else begin
      if (load)
        piso <= {wnr, addr, {DATA_WIDTH{wnr == SCI_WNR_WRITE}} & wdata};
      else if (shift)
        piso <= {piso[FL-2:0], 1'b0};
      if (capture)
        sipo <= rd_next;
    end
  end

endmodule

// File: rtl/sci_master.sv
// SCI bus initiator: serialises one command per frame and returns one response per command.
module sci_master
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic          CLK,
  input  logic          RST,
  sci_master_if.master  bus
);
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  sci_state_e            state;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         to_cnt;
  logic                  cmd_ready, csn, rsp_valid, rsp_err, wnr_q, req;
  logic [DATA_WIDTH-1:0] rsp_rdata, rd_next;
  logic                  hs, in_tx, in_rd, ack;

  assign hs    = (state == S_IDLE) && cmd_ready && bus.CMD_VALID;
  assign in_tx = state inside {S_CMD, S_ADDR, S_WDATA};
  assign in_rd = state inside {S_RWAIT, S_RDATA};
  // ACK is only looked at while a response is awaited; other states never see it.
  assign ack   = (in_rd || state == S_WACK) && bus.SCI_ACK;

  sci_frame_shifter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .CLK     (CLK),
    .RST     (RST),
    .load    (hs),
    .shift   (in_tx),
    .capture (in_rd && ack),
    .wnr     (bus.CMD_WNR),
    .addr    (bus.CMD_ADDR),
    .wdata   (bus.CMD_WDATA),
    .resp    (bus.SCI_RESP),
    .req     (req),
    .rd_next (rd_next)
  );

  assign bus.CMD_READY = cmd_ready;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;
  assign bus.RSP_ERR   = rsp_err;
  assign bus.SCI_CSN   = csn;
  assign bus.SCI_REQ   = req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      cmd_ready <= 1'b0;
      csn       <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wnr_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (hs) begin
            cmd_ready <= 1'b0;
            csn       <= 1'b0;
            wnr_q     <= bus.CMD_WNR;
            state     <= S_CMD;
          end else begin
            cmd_ready <= 1'b1;
          end
        S_CMD: begin
          cnt   <= '0;
          state <= S_ADDR;
        end
        S_ADDR:
          if (cnt == CW'(ADDR_WIDTH - 1)) begin
            cnt    <= '0;
            to_cnt <= '0;
            state  <= (wnr_q == SCI_WNR_WRITE) ? S_WDATA : S_RWAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_WDATA:
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            cnt    <= '0;
            to_cnt <= '0;
            state  <= S_WACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        // cnt counts ACKed read bits here; an ACK on the expiry cycle still wins.
        S_WACK, S_RWAIT, S_RDATA:
          if (ack) begin
            to_cnt <= '0;
            if (state == S_WACK || cnt == CW'(DATA_WIDTH - 1)) begin
              cnt       <= '0;
              csn       <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= S_GAP;
              if (state != S_WACK) rsp_rdata <= rd_next;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_RDATA;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            cnt       <= '0;
            to_cnt    <= '0;
            csn       <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= S_GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        S_GAP:
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt       <= '0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_master.sv
// Self-checking bench for sci_master with a pattern-driven SCI slave and a register-map model.
module tb_sci_master;
  localparam int AW = 8, DW = 8, TO = 16, GAP = 2, PN = 512;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0, bad = 0, cyc = 0;

  bit            ack_pat [PN];
  bit            resp_pat[PN];
  logic [DW-1:0] exp_rdata;
  logic [7:0]    rm   [256];
  bit            rm_v [256];

  bit            o_req [PN];
  int            o_low, o_fall, o_rise, o_gap, o_ready_hi, o_rspv_early, o_rspv_extra;
  logic          o_rspv, o_err;
  logic [DW-1:0] o_rdata;

  sci_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  sci_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // SCI lines are meaningless outside the response window; drive junk there.
  task automatic noise();
    bus.SCI_ACK  = 1'($urandom_range(0, 1));
    bus.SCI_RESP = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_pat();
    for (int i = 0; i < PN; i++) begin
      ack_pat[i]  = 1'b0;
      resp_pat[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference: walk the ACK pattern; abort after TO consecutive silent cycles.
  task automatic model(input bit wnr, output int wl, output bit err, output logic [DW-1:0] rd);
    int nack, idle;
    logic [DW-1:0] acc;
    nack = 0; idle = 0; acc = '0; wl = PN; err = 1'b1; rd = exp_rdata;
    for (int w = 0; w < PN; w++) begin
      if (ack_pat[w]) begin
        idle = 0;
        nack++;
        acc = {acc[DW-2:0], resp_pat[w]};
        if (wnr || nack == DW) begin
          wl = w + 1; err = 1'b0;
          if (!wnr) rd = acc;
          return;
        end
      end else begin
        idle++;
        if (idle == TO) begin
          wl = w + 1; err = 1'b1;
          return;
        end
      end
    end
  endtask

  // Issues one command, plays the slave from ack_pat/resp_pat and checks the whole frame.
  task automatic run_cmd(input bit wnr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    int n, flen, w, wl, mism;
    bit err;
    logic [DW-1:0] rd;
    logic [16:0] fr;
    model(wnr, wl, err, rd);
    flen = 1 + AW + (wnr ? DW : 0);
    fr   = {wnr, a, d};
    bus.CMD_WNR = wnr; bus.CMD_ADDR = a; bus.CMD_WDATA = d; bus.CMD_VALID = 1'b1;
    n = 0;
    while (bus.CMD_READY !== 1'b1 && n < 50) begin noise(); tick(); n++; end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL ready_wait: CMD_READY=%b after %0d cycles, required 1", bus.CMD_READY, n);
      return;
    end
    noise();
    tick();
    if (!hold) bus.CMD_VALID = 1'b0;
    bus.CMD_WNR = 1'($urandom_range(0, 1)); bus.CMD_ADDR = 8'($urandom); bus.CMD_WDATA = 8'($urandom);
    o_fall = cyc; o_low = 0; o_ready_hi = 0; o_rspv_early = 0; mism = 0;
    while (bus.SCI_CSN === 1'b0 && o_low < 400) begin
      if (o_low < PN) o_req[o_low] = bus.SCI_REQ;
      if (bus.SCI_REQ !== ((o_low < flen) ? fr[16 - o_low] : 1'b0)) mism++;
      if (bus.CMD_READY !== 1'b0) o_ready_hi++;
      if (bus.RSP_VALID !== 1'b0) o_rspv_early++;
      w = o_low - flen;
      if (w >= 0 && w < PN) begin bus.SCI_ACK = ack_pat[w]; bus.SCI_RESP = resp_pat[w]; end
      else noise();
      tick();
      o_low++;
    end
    o_rise = cyc; o_rspv = bus.RSP_VALID; o_err = bus.RSP_ERR; o_rdata = bus.RSP_RDATA;
    o_rspv_extra = 0; n = 0;
    while (bus.CMD_READY !== 1'b1 && n < 50) begin
      if (n > 0 && bus.RSP_VALID !== 1'b0) o_rspv_extra++;
      if (bus.SCI_CSN !== 1'b1) o_rspv_extra++;
      noise(); tick(); n++;
    end
    o_gap = n;
    total++; if (mism != 0) begin bad++; $display("FAIL req_stream: %0d wrong REQ cycles, required 0", mism); end
    total++; if (o_low != flen + wl) begin bad++; $display("FAIL csn_low_len: got %0d, required %0d", o_low, flen + wl); end
    total++; if (o_ready_hi != 0 || o_rspv_early != 0) begin bad++; $display("FAIL in_frame: ready_hi=%0d rspv=%0d, required 0/0", o_ready_hi, o_rspv_early); end
    total++; if (o_rspv !== 1'b1) begin bad++; $display("FAIL rsp_valid: got %b, required 1", o_rspv); end
    total++; if (o_err !== err) begin bad++; $display("FAIL rsp_err: got %b, required %b", o_err, err); end
    total++; if (o_rdata !== rd) begin bad++; $display("FAIL rsp_rdata: got %h, required %h", o_rdata, rd); end
    total++; if (o_gap != GAP || o_rspv_extra != 0) begin bad++; $display("FAIL gap: cycles=%0d extra=%0d, required %0d/0", o_gap, o_rspv_extra, GAP); end
    exp_rdata = rd;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    total++;
    if (bus.SCI_CSN !== 1'b1 || bus.SCI_REQ !== 1'b0 || bus.CMD_READY !== 1'b0 ||
        bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0 || bus.RSP_RDATA !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: csn=%b req=%b rdy=%b rv=%b err=%b rd=%h, required 1 0 0 0 0 00",
               bus.SCI_CSN, bus.SCI_REQ, bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA);
    end
    tick();
    RST = 1'b0;
    exp_rdata = '0;
    tick();
    total++;
    if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b, required 1", bus.CMD_READY); end
  endtask

  task automatic test_write();
    clear_pat();
    ack_pat[3] = 1'b1;
    run_cmd(1'b1, 8'hA5, 8'h3C, 1'b0);
    total++; if (o_low != 21) begin bad++; $display("FAIL write_csn_low: got %0d, required 21", o_low); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL write_err: got %b, required 0", o_err); end
  endtask

  task automatic test_read();
    logic [7:0] v;
    v = 8'hC3;
    clear_pat();
    for (int k = 0; k < 8; k++) begin ack_pat[4 + k] = 1'b1; resp_pat[4 + k] = v[7 - k]; end
    run_cmd(1'b0, 8'h0F, 8'h77, 1'b0);
    total++; if (o_rdata !== 8'hC3) begin bad++; $display("FAIL read_data: got %h, required c3", o_rdata); end
  endtask

  task automatic test_read_gapped();
    logic [7:0] v;
    v = 8'h5A;
    clear_pat();
    for (int k = 0; k < 4; k++) begin
      ack_pat[k] = 1'b1;     resp_pat[k] = v[7 - k];
      ack_pat[9 + k] = 1'b1; resp_pat[9 + k] = v[3 - k];
    end
    run_cmd(1'b0, 8'h21, 8'h00, 1'b0);
    total++; if (o_rdata !== 8'h5A || o_err !== 1'b0) begin bad++; $display("FAIL read_gapped: data=%h err=%b, required 5a 0", o_rdata, o_err); end
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    clear_pat();
    run_cmd(1'b1, 8'h10, 8'hEE, 1'b0);
    total++; if (o_low != 33 || o_err !== 1'b1) begin bad++; $display("FAIL write_timeout: low=%0d err=%b, required 33 1", o_low, o_err); end
    total++; if (o_rdata !== 8'h5A) begin bad++; $display("FAIL timeout_hold: got %h, required 5a", o_rdata); end
    // ACK arriving on the last allowed cycle must complete normally.
    clear_pat();
    ack_pat[TO - 1] = 1'b1;
    run_cmd(1'b1, 8'h11, 8'h01, 1'b0);
    total++; if (o_low != 17 + TO || o_err !== 1'b0) begin bad++; $display("FAIL ack_at_expiry: low=%0d err=%b, required %0d 0", o_low, o_err, 17 + TO); end
    v = 8'h96;
    clear_pat();
    for (int k = 0; k < 8; k++) begin ack_pat[15 + 16 * k] = 1'b1; resp_pat[15 + 16 * k] = v[7 - k]; end
    run_cmd(1'b0, 8'h12, 8'h00, 1'b0);
    total++; if (o_rdata !== 8'h96 || o_err !== 1'b0) begin bad++; $display("FAIL read_max_gaps: data=%h err=%b, required 96 0", o_rdata, o_err); end
    clear_pat();
    for (int k = 0; k < 3; k++) ack_pat[k] = 1'b1;
    run_cmd(1'b0, 8'h13, 8'h00, 1'b0);
    total++; if (o_rdata !== 8'h96 || o_err !== 1'b1) begin bad++; $display("FAIL read_timeout: data=%h err=%b, required 96 1", o_rdata, o_err); end
  endtask

  task automatic test_back_to_back();
    int rise1;
    clear_pat();
    ack_pat[0] = 1'b1;
    run_cmd(1'b1, 8'h30, 8'h31, 1'b1);
    rise1 = o_rise;
    run_cmd(1'b1, 8'h32, 8'h33, 1'b1);
    bus.CMD_VALID = 1'b0;
    total++; if (o_fall - rise1 != GAP + 1) begin bad++; $display("FAIL b2b_csn_high: got %0d, required %0d", o_fall - rise1, GAP + 1); end
  endtask

  task automatic gen_pat(input bit wnr, input logic [7:0] val);
    int w, g;
    w = 0;
    clear_pat();
    for (int k = 0; k < (wnr ? 1 : DW); k++) begin
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      w += g;
      if (w < PN) begin ack_pat[w] = 1'b1; resp_pat[w] = val[7 - k]; end
      w++;
    end
  endtask

  task automatic test_random();
    bit wnr;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) rm_v[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wnr = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 3) + 8'h80);
      d = 8'($urandom);
      gen_pat(wnr, wnr ? d : rm[a]);
      run_cmd(wnr, a, d, 1'b0);
      if (wnr && o_err === 1'b0) begin rm[a] = d; rm_v[a] = 1'b1; end
      if (!wnr && o_err === 1'b0 && rm_v[a]) begin
        total++;
        if (o_rdata !== rm[a]) begin bad++; $display("FAIL regmap_read: addr %h got %h, required %h", a, o_rdata, rm[a]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    logic [7:0] ra, rdv;
    bus.CMD_WNR = 1'b1; bus.CMD_ADDR = 8'hF0; bus.CMD_WDATA = 8'h0F; bus.CMD_VALID = 1'b1;
    seen = 0;
    while (bus.CMD_READY !== 1'b1 && seen < 50) begin tick(); seen++; end
    tick();
    bus.CMD_VALID = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_rdata = '0;
    total++;
    if (bus.SCI_CSN !== 1'b1 || bus.SCI_REQ !== 1'b0 || bus.CMD_READY !== 1'b0 || bus.RSP_VALID !== 1'b0 || bus.RSP_RDATA !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: csn=%b req=%b rdy=%b rv=%b rd=%h, required 1 0 0 0 00",
               bus.SCI_CSN, bus.SCI_REQ, bus.CMD_READY, bus.RSP_VALID, bus.RSP_RDATA);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin noise(); if (bus.RSP_VALID !== 1'b0 || bus.SCI_CSN !== 1'b1) seen++; tick(); end
    total++; if (seen != 0) begin bad++; $display("FAIL no_rsp_after_reset: %0d bad cycles, required 0", seen); end
    // Loopback through a register-map slave decoded from the observed REQ stream.
    clear_pat();
    ack_pat[2] = 1'b1;
    run_cmd(1'b1, 8'h42, 8'h99, 1'b0);
    for (int k = 0; k < 8; k++) begin ra[7 - k] = o_req[1 + k]; rdv[7 - k] = o_req[9 + k]; end
    rm[ra] = rdv;
    clear_pat();
    for (int k = 0; k < 8; k++) begin ack_pat[1 + k] = 1'b1; resp_pat[1 + k] = rm[8'h42][7 - k]; end
    run_cmd(1'b0, 8'h42, 8'h00, 1'b0);
    total++; if (o_rdata !== 8'h99) begin bad++; $display("FAIL loopback_read: got %h, required 99", o_rdata); end
  endtask

  initial begin
    bus.CMD_VALID = 1'b0; bus.CMD_WNR = 1'b0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
    bus.SCI_ACK = 1'b0; bus.SCI_RESP = 1'b0;
    exp_rdata = '0;
    test_reset();
    test_write();
    test_read();
    test_read_gapped();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
